rgb_pwm_fader: RTL and testbench
================================

// Module: rgb_pwm_fader
// PURPOSE
//  - Downstream of the RGB colour-cycle FSM: consumes its on/off red/green/blue levels, drives the board RGB LED pins.
//  - Replaces hard on/off switching with per-channel PWM brightness that ramps smoothly toward the commanded level.
//  - Single clock domain (12 MHz board clock); three identical channel engines share one PWM counter and one ramp prescaler.
// PARAMETERS
//  PWM_WIDTH      8     duty/PWM counter width; PWM period = 2**PWM_WIDTH clk; DMAX = 2**PWM_WIDTH-1
//  RAMP_INTERVAL  4000  clk cycles per ramp tick (>=1); full 0->DMAX ramp = ceil(DMAX/RAMP_STEP) ticks (~85 ms at defaults)
//  RAMP_STEP      1     duty change per tick (1..DMAX)
// PORTS
//  clk        in   1          system clock, all logic posedge
//  rst        in   1          asynchronous active-high reset
//  red_in     in   1          commanded red level from colour FSM (1 = on)
//  green_in   in   1          commanded green level
//  blue_in    in   1          commanded blue level
//  red        out  1          red LED drive (registered)
//  green      out  1          green LED drive (registered)
//  blue       out  1          blue LED drive (registered)
//  busy       out  1          1 while any channel is in RAMP_UP or RAMP_DOWN (registered)
// BEHAVIOUR
//  - Reset (async assert, sync release): inputs_q=0, all duty=0, all states OFF, pwm_cnt=0, presc=0, tick=0, busy=0, red/green/blue=inactive level.
//  - Inputs registered once (inputs_q); FSM sees inputs_q -> 1-cycle input latency.
//  - pwm_cnt: free-running PWM_WIDTH-bit up counter, wraps DMAX->0.
//  - presc: counts 0..RAMP_INTERVAL-1 and wraps; tick=1 for exactly one cycle, the cycle after presc==RAMP_INTERVAL-1.
//  - Per-channel states: OFF, RAMP_UP, ON, RAMP_DOWN; transitions are evaluated every cycle, duty changes only on tick.
//      OFF:       in_q=1 -> RAMP_UP (duty stays 0 until the next tick)
//      RAMP_UP:   in_q=0 -> RAMP_DOWN (no duty change that cycle);
//                 else on tick duty=min(duty+RAMP_STEP,DMAX), -> ON when the new duty==DMAX
//      ON:        in_q=0 -> RAMP_DOWN
//      RAMP_DOWN: in_q=1 -> RAMP_UP (no duty change that cycle);
//                 else on tick duty=max(duty-RAMP_STEP,0), -> OFF when the new duty==0
//  - Reversal mid-ramp resumes from the current duty; there is no restart from 0/DMAX.
//  - Saturation: arithmetic is done at PWM_WIDTH+1 bits and clamped; duty never wraps.
//  - Glitch-free update: shadow duty_sh loads duty when pwm_cnt==DMAX; a duty change takes effect at the next PWM period start.
//  - Raw output level: ON state -> 1 constantly; OFF state -> 0 constantly; ramp states -> (pwm_cnt < duty_sh).
//  - Output registered: pin = raw level of the previous cycle. busy = OR of the three ramp-state flags, registered.
//  - Simultaneous tick and direction change on one channel: the direction change wins; no step is applied that cycle.
//  - rst asserted mid-ramp: immediate return to the reset values above; no partial state survives.
// CONFIGURATION
//  - LED_ACTIVE_LOW_EN defined: red/green/blue are inverted at the output register (on = 0); reset value of these outputs = 1.
//  - LED_ACTIVE_LOW_EN not defined: outputs are active-high; reset value = 0.
//  - busy polarity is unaffected by the macro.
// TESTING (bench params PWM_WIDTH=4, RAMP_INTERVAL=4, RAMP_STEP=5 -> DMAX=15)
//  1. rst pulse mid-run -> all outputs inactive, busy=0 immediately (async), held while rst=1; duty=0 after release.
//  2. red_in 0->1 and held -> busy=1 two cycles later; duty 5,10,15 on three successive ticks; state ON, red constant 1, busy drops.
//  3. red ON, then red_in=0 -> duty 10,5,0 on ticks, then OFF; red stays 0 from then on.
//  4. In RAMP_UP at duty=10, drop red_in -> RAMP_DOWN with no step that cycle; next tick duty=5 (no jump to 15 or 0).
//  5. Duty=5, check one PWM period after the shadow load -> red high for exactly 5 of 16 clk; change lands only at pwm_cnt wrap.
//  6. All three inputs toggled together at each tick boundary -> states stay independent; busy=1 until the last channel settles; LED_ACTIVE_LOW_EN build inverts every pin check above.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: per-channel PWM brightness fader for the board RGB LED.
// Each of the three colour commands ramps its duty toward full or zero
// brightness in RAMP_STEP increments, one step every RAMP_INTERVAL clocks.
// The PWM counter and the ramp prescaler are shared by all channels.
// Optional build macro LED_ACTIVE_LOW_EN: when defined, the LED pins are
// inverted (on = 0) and reset to 1. busy keeps its active-high polarity.
module rgb_pwm_fader #(
  parameter int PWM_WIDTH     = 8,
  parameter int RAMP_INTERVAL = 4000,
  parameter int RAMP_STEP     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic red,
  output logic green,
  output logic blue,
  output logic busy
);

  localparam logic [PWM_WIDTH-1:0] DMAX    = '1;
  localparam logic [PWM_WIDTH:0]   DMAX_X  = {1'b0, DMAX};
  localparam logic [PWM_WIDTH:0]   STEP_X  = (PWM_WIDTH+1)'(RAMP_STEP);
  localparam logic [PWM_WIDTH-1:0] STEP_N  = PWM_WIDTH'(RAMP_STEP);
  localparam int                   PRESC_W = (RAMP_INTERVAL > 1) ? $clog2(RAMP_INTERVAL) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(RAMP_INTERVAL - 1);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } chan_state_t;

  logic [2:0]           inputs_q;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PRESC_W-1:0]   presc;
  logic                 tick;
  chan_state_t          state   [3];
  logic [PWM_WIDTH-1:0] duty    [3];
  logic [PWM_WIDTH-1:0] duty_sh [3];
  logic [PWM_WIDTH-1:0] duty_up [3];
  logic [PWM_WIDTH-1:0] duty_dn [3];
  logic [2:0]           raw;
  logic [2:0]           ramping;
  logic [2:0]           led_q;

  // Register the colour commands once; the channel FSMs only look at this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inputs_q <= '0;
    end else begin
      inputs_q <= {blue_in, green_in, red_in};
    end
  end

  // Shared timebase: free-running PWM counter plus the ramp prescaler that
  // emits a one-cycle tick the cycle after it reaches its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      presc   <= '0;
      tick    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
      tick    <= (presc == PRESC_LAST);
      if (presc == PRESC_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // Saturating next-duty candidates, computed one bit wider so nothing wraps.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      duty_up[i] = '0;
      duty_dn[i] = '0;
      if (({1'b0, duty[i]} + STEP_X) > DMAX_X) begin
        duty_up[i] = DMAX;
      end else begin
        duty_up[i] = duty[i] + STEP_N;
      end
      if ({1'b0, duty[i]} > STEP_X) begin
        duty_dn[i] = duty[i] - STEP_N;
      end
    end
  end

  // Channel engines: direction follows the command every cycle, duty only
  // moves on a tick, and a direction change suppresses the step that cycle.
  // The shadow duty is reloaded at the end of each PWM period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i]   <= OFF;
        duty[i]    <= '0;
        duty_sh[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pwm_cnt == DMAX) begin
          duty_sh[i] <= duty[i];
        end
        case (state[i])
          OFF: begin
            if (inputs_q[i]) begin
              state[i] <= RAMP_UP;
            end
          end
          RAMP_UP: begin
            if (!inputs_q[i]) begin
              state[i] <= RAMP_DOWN;
            end else if (tick) begin
              duty[i] <= duty_up[i];
              if (duty_up[i] == DMAX) begin
                state[i] <= ON;
              end
            end
          end
          ON: begin
            if (!inputs_q[i]) begin
              state[i] <= RAMP_DOWN;
            end
          end
          RAMP_DOWN: begin
            if (inputs_q[i]) begin
              state[i] <= RAMP_UP;
            end else if (tick) begin
              duty[i] <= duty_dn[i];
              if (duty_dn[i] == '0) begin
                state[i] <= OFF;
              end
            end
          end
          default: begin
            state[i] <= OFF;
          end
        endcase
      end
    end
  end

  // Raw pin level: steady in ON/OFF, PWM-compared against the shadow while ramping.
  always_comb begin
    raw     = '0;
    ramping = '0;
    for (int i = 0; i < 3; i++) begin
      ramping[i] = (state[i] == RAMP_UP) || (state[i] == RAMP_DOWN);
      case (state[i])
        ON:      raw[i] = 1'b1;
        OFF:     raw[i] = 1'b0;
        default: raw[i] = (pwm_cnt < duty_sh[i]);
      endcase
    end
  end

  // Output register for the LED pins (with optional inversion) and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef LED_ACTIVE_LOW_EN
      led_q <= '1;
`else
      led_q <= '0;
`endif
      busy  <= 1'b0;
    end else begin
`ifdef LED_ACTIVE_LOW_EN
      led_q <= ~raw;
`else
      led_q <= raw;
`endif
      busy  <= |ramping;
    end
  end

  assign red   = led_q[0];
  assign green = led_q[1];
  assign blue  = led_q[2];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: randomized and directed checks of rgb_pwm_fader against
// a behavioural model of the fading rules (DMAX=15, step 5, tick every 4 clk).
module tb_rgb_pwm_fader;

  localparam int PWM_WIDTH     = 4;
  localparam int RAMP_INTERVAL = 4;
  localparam int RAMP_STEP     = 5;
  localparam int DMAX          = (1 << PWM_WIDTH) - 1;

`ifdef LED_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  localparam int S_OFF  = 0;
  localparam int S_UP   = 1;
  localparam int S_ON   = 2;
  localparam int S_DOWN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cmd = 3'b000;
  logic       red, green, blue, busy;
  logic [2:0] pins;
  assign pins = {blue, green, red};

  string ch_name [3] = '{"red", "green", "blue"};

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int         m_inq  [3];
  int         m_st   [3];
  int         m_duty [3];
  int         m_sh   [3];
  int         m_cnt;
  int         m_presc;
  int         m_tick;
  logic [2:0] m_pin;
  logic       m_busy;
  int         n_st   [3];
  int         n_duty [3];
  int         n_sh   [3];
  logic [2:0] n_pin;
  int         lvl;
  bit         any_ramp;

  rgb_pwm_fader #(
    .PWM_WIDTH    (PWM_WIDTH),
    .RAMP_INTERVAL(RAMP_INTERVAL),
    .RAMP_STEP    (RAMP_STEP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .red_in  (cmd[0]),
    .green_in(cmd[1]),
    .blue_in (cmd[2]),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: each cycle, every channel chases its command using
  // saturating min/max arithmetic; pins show the previous cycle's level.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_inq[c] = 0; m_st[c] = S_OFF; m_duty[c] = 0; m_sh[c] = 0;
      end
      m_cnt = 0; m_presc = 0; m_tick = 0;
      m_pin = {3{ACT_LOW}};
      m_busy = 1'b0;
    end else begin
      any_ramp = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (m_st[c] == S_UP || m_st[c] == S_DOWN) any_ramp = 1'b1;
        if (m_st[c] == S_ON) lvl = 1;
        else if (m_st[c] == S_OFF) lvl = 0;
        else lvl = (m_cnt < m_sh[c]) ? 1 : 0;
        n_pin[c]  = (lvl != 0) ^ ACT_LOW;
        n_sh[c]   = (m_cnt == DMAX) ? m_duty[c] : m_sh[c];
        n_st[c]   = m_st[c];
        n_duty[c] = m_duty[c];
        if (m_st[c] == S_OFF) begin
          if (m_inq[c] != 0) n_st[c] = S_UP;
        end else if (m_st[c] == S_ON) begin
          if (m_inq[c] == 0) n_st[c] = S_DOWN;
        end else if (m_st[c] == S_UP) begin
          if (m_inq[c] == 0) n_st[c] = S_DOWN;
          else if (m_tick != 0) begin
            n_duty[c] = (m_duty[c] + RAMP_STEP > DMAX) ? DMAX : m_duty[c] + RAMP_STEP;
            if (n_duty[c] == DMAX) n_st[c] = S_ON;
          end
        end else begin
          if (m_inq[c] != 0) n_st[c] = S_UP;
          else if (m_tick != 0) begin
            n_duty[c] = (m_duty[c] - RAMP_STEP < 0) ? 0 : m_duty[c] - RAMP_STEP;
            if (n_duty[c] == 0) n_st[c] = S_OFF;
          end
        end
      end
      for (int c = 0; c < 3; c++) begin
        m_st[c] = n_st[c]; m_duty[c] = n_duty[c]; m_sh[c] = n_sh[c];
        m_inq[c] = cmd[c] ? 1 : 0;
      end
      m_pin   = n_pin;
      m_busy  = any_ramp;
      m_tick  = (m_presc == RAMP_INTERVAL - 1) ? 1 : 0;
      m_presc = (m_presc + 1) % RAMP_INTERVAL;
      m_cnt   = (m_cnt + 1) % (DMAX + 1);
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== {3{ACT_LOW}}) begin
        n_fail++;
        $display("[TB] FAIL reset_pins got=%b want=%b", pins, {3{ACT_LOW}});
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_busy got=%b want=0", busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp_up();
    cmd[0] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL ramp_up_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL ramp_up_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
    end
    n_cmp++;
    if (red !== ~ACT_LOW || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ramp_up_settled red=%b busy=%b want red=%b busy=0", red, busy, ~ACT_LOW);
    end
  endtask

  task automatic test_ramp_down();
    cmd[0] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL ramp_down_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL ramp_down_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
    end
    n_cmp++;
    if (red !== ACT_LOW || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ramp_down_settled red=%b busy=%b want red=%b busy=0", red, busy, ACT_LOW);
    end
  endtask

  task automatic test_reversal();
    bit found = 1'b0;
    cmd[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL reversal_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      if (m_st[0] == S_UP && m_duty[0] == 10) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL reversal_wait got=timeout want=duty10");
    end
    cmd[0] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL reversal_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL reversal_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit settled = 1'b0;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          n_cmp++;
          if (pins[c] !== m_pin[c]) begin
            n_fail++;
            $display("[TB] FAIL b2b_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
          end
        end
        n_cmp++;
        if (busy !== m_busy) begin
          n_fail++;
          $display("[TB] FAIL b2b_busy t=%0t got=%b want=%b", $time, busy, m_busy);
        end
        if (m_tick != 0) break;
      end
      cmd = (n == 0) ? 3'b101 : ~cmd;
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL b2b_settle_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL b2b_settle_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
      if (k > 4 && busy === 1'b0) begin
        settled = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!settled) begin
      n_fail++;
      $display("[TB] FAIL b2b_settle_wait got=busy want=idle");
    end
  endtask

  task automatic test_random();
    int idx;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL random_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL random_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
      if ($urandom_range(9, 0) == 0) begin
        idx = $urandom_range(2, 0);
        cmd[idx] = ~cmd[idx];
      end
    end
  endtask

  task automatic test_mid_reset();
    cmd = 3'b111;
    for (int k = 0; k < 9; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (pins !== {3{ACT_LOW}}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_pins got=%b want=%b", pins, {3{ACT_LOW}});
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_busy got=%b want=0", busy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== {3{ACT_LOW}} || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_hold pins=%b busy=%b want pins=%b busy=0", pins, busy, {3{ACT_LOW}});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pins[c] !== m_pin[c]) begin
          n_fail++;
          $display("[TB] FAIL post_reset_%s t=%0t got=%b want=%b", ch_name[c], $time, pins[c], m_pin[c]);
        end
      end
      n_cmp++;
      if (busy !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL post_reset_busy t=%0t got=%b want=%b", $time, busy, m_busy);
      end
    end
  endtask

  initial begin
    $display("[TB] rgb_pwm_fader bench start");
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
